// File: rtl/hdc_class_pkg.sv
// hdc_class_pkg: shared sizes and scheduler state encoding for the class-vector sweep
package hdc_class_pkg;
   localparam int NUM_CLASSES = 8;
   localparam int NUM_FRAMES  = 3;
   localparam int FRAME_W     = 64;
   localparam int CLASS_ID_W  = 3;
   localparam int FRAME_IDX_W = 2;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
endpackage

// File: rtl/class_vec_scheduler_if.sv
// class_vec_scheduler_if: valid/ready beat stream from the scheduler to the similarity stage
interface class_vec_scheduler_if;
   import hdc_class_pkg::*;
   logic                   m_valid;
   logic                   m_ready;
   logic [FRAME_W-1:0]     m_data;
   logic [CLASS_ID_W-1:0]  m_class_id;
   logic [FRAME_IDX_W-1:0] m_frame_index;
   logic                   m_last_frame;
   logic                   m_last_class;
   modport master (output m_valid, m_data, m_class_id, m_frame_index, m_last_frame, m_last_class, input m_ready);
   modport slave  (input m_valid, m_data, m_class_id, m_frame_index, m_last_frame, m_last_class, output m_ready);
endinterface

// File: rtl/class_mask_next.sv
// class_mask_next: lowest set mask bit above cur_id, or the lowest set bit overall when first=1
module class_mask_next import hdc_class_pkg::*; (
   input  logic [NUM_CLASSES-1:0] mask,
   input  logic [CLASS_ID_W-1:0]  cur_id,
   input  logic                   first,
   output logic [CLASS_ID_W-1:0]  next_id,
   output logic                   has_next
);
   // scan downward so the lowest qualifying bit is the one left standing
   always_comb begin
      next_id  = '0;
      has_next = 1'b0;
      for (int i = NUM_CLASSES - 1; i >= 0; i--)
         if (mask[i] && (first || CLASS_ID_W'(i) > cur_id)) begin
            next_id  = CLASS_ID_W'(i);
            has_next = 1'b1;
         end
   end
endmodule

// File: rtl/class_vec_scheduler.sv
// class_vec_scheduler: sweeps enabled classes and their frames through the class-vector ROM into a beat stream
module class_vec_scheduler import hdc_class_pkg::*; (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [NUM_CLASSES-1:0] class_mask,
   output logic                   busy,
   output logic                   done,
   output logic [CLASS_ID_W-1:0]  rom_frame_id,
   output logic [FRAME_IDX_W-1:0] rom_frame_index,
   input  logic [FRAME_W-1:0]     rom_data,
   class_vec_scheduler_if.master  m
);
   logic [1:0]             state, state_d;
   logic [NUM_CLASSES-1:0] mask_q;
   logic [CLASS_ID_W-1:0]  first_id, nxt_id;
   logic                   first_has, nxt_has;
   logic                   load, last_frame, last_class, go;

   class_mask_next u_first (.mask(class_mask), .cur_id('0), .first(1'b1), .next_id(first_id), .has_next(first_has));
   class_mask_next u_next  (.mask(mask_q), .cur_id(rom_frame_id), .first(1'b0), .next_id(nxt_id), .has_next(nxt_has));

   // state register
   always_ff @(posedge clk) state <= rst ? IDLE : state_d;

   // next state: abort wins outside IDLE, RUN leaves once the final beat is loaded
   always_comb
      state_d = state == IDLE ? (go ? RUN : IDLE)
              : abort         ? IDLE
              : state == RUN  ? (load && last_class ? DRAIN : RUN)
              : m.m_ready     ? IDLE : DRAIN;

   // status and handshake decode
   always_comb begin
      busy       = state != IDLE;
      load       = !m.m_valid || m.m_ready;
      last_frame = rom_frame_index == FRAME_IDX_W'(NUM_FRAMES - 1);
      last_class = last_frame && !nxt_has;
      go         = start && !abort && first_has;
   end

   // address sequencing, output register and done pulse
   always_ff @(posedge clk)
      if (rst) begin
         done            <= 1'b0;
         mask_q          <= '0;
         rom_frame_id    <= '0;
         rom_frame_index <= '0;
         m.m_valid       <= 1'b0;
         m.m_data        <= '0;
         m.m_class_id    <= '0;
         m.m_frame_index <= '0;
         m.m_last_frame  <= 1'b0;
         m.m_last_class  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (go) begin
               mask_q          <= class_mask;
               rom_frame_id    <= first_id;
               rom_frame_index <= '0;
            end else if (start && !abort)
               done <= 1'b1;
         end else if (abort)
            m.m_valid <= 1'b0;
         else if (state == RUN && load) begin
            m.m_valid       <= 1'b1;
            m.m_data        <= rom_data;
            m.m_class_id    <= rom_frame_id;
            m.m_frame_index <= rom_frame_index;
            m.m_last_frame  <= last_frame;
            m.m_last_class  <= last_class;
            rom_frame_index <= last_frame ? '0 : rom_frame_index + 1'b1;
            if (last_frame && nxt_has)
               rom_frame_id <= nxt_id;
         end else if (state == DRAIN && m.m_ready) begin
            m.m_valid <= 1'b0;
            done      <= 1'b1;
         end
      end
endmodule
